npu_job_sequencer: RTL and testbench



---
 rtl/npu_seq_pkg.sv | 23 ++
 rtl/npu_seq_row_tracker.sv | 38 +++
 rtl/npu_job_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_npu_job_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_seq_pkg.sv
// Shared definitions for the NPU job sequencer.
//   seq_state_t    : sequencer FSM state encoding
//   layer_w()      : width of the layer index for a given layer count
//   CLASS_ALL_ONES : class value reported when the watchdog ends a job
package npu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC_RUN,
        ST_MAC_DRAIN,
        ST_RESULT_WAIT,
        ST_DONE
    } seq_state_t;

    localparam int CLASS_W_MAX = 32;
    localparam logic [CLASS_W_MAX-1:0] CLASS_ALL_ONES = '1;

    // One extra bit so the index can also express "one past the last layer".
    function automatic int layer_w(input int num_layers);
        return $clog2(num_layers) + 1;
    endfunction

endpackage

// File: rtl/npu_seq_row_tracker.sv
// Counts CPU image rows and flags when the auto-start threshold is reached.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset
//   write_row_p      : one pulse per row written
//   clear_p          : zeroes the count; beats a simultaneous write_row_p
//   start_thr        : start threshold, 0 disables auto-start
//   rows_written     : saturating row count (registered)
//   thr_met          : threshold non-zero and reached
module npu_seq_row_tracker
    import npu_seq_pkg::*;
#(
    parameter int ROW_CNT_W = 6,
    parameter int MAX_ROWS  = 63
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 write_row_p,
    input  logic                 clear_p,
    input  logic [ROW_CNT_W-1:0] start_thr,
    output logic [ROW_CNT_W-1:0] rows_written,
    output logic                 thr_met
);

    localparam logic [ROW_CNT_W-1:0] ROWS_SAT = ROW_CNT_W'(MAX_ROWS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rows_written <= '0;
        end else if (clear_p) begin
            rows_written <= '0;
        end else if (write_row_p && (rows_written != ROWS_SAT)) begin
            rows_written <= rows_written + 1'b1;
        end
    end

    assign thr_met = (start_thr != '0) && (rows_written >= start_thr);

endmodule

// File: rtl/npu_job_sequencer.sv
// NPU job sequencer: auto-starts inference once enough image rows are written,
// runs one MAC burst per layer, waits for each layer's writeback, then captures
// the softmax class. Supports abort and overflow latching.
//
// Optional feature, macro NPU_SEQ_WATCHDOG_EN: a watchdog bounds the time spent
// in MAC_DRAIN / RESULT_WAIT; on expiry the job ends in DONE with timeout_o=1
// and class_o all ones. Without the macro timeout_o is tied 0.
//
// Ports:
//   clk, resetn         : clock, asynchronous active-low reset
//   cfg_start_thr_i     : rows needed to auto-start (0 = disabled)
//   write_row_p_i       : CPU row written pulse
//   frame_clear_p_i     : clear rows/result/latches, DONE -> IDLE
//   abort_p_i           : cancel everything, back to IDLE
//   layer_len_i         : per-layer burst length, layer 0 in LSBs
//   layer_mac_mask_i    : per-layer MAC enable mask
//   layer_done_p_i      : writeback of current layer complete
//   result_valid_p_i    : softmax result valid, result_class_i its index
//   mac/act_overflow_i  : per-lane overflow flags
//   mac_enable_o        : active lane mask during a burst
//   mac_start/last_p_o  : first / last burst cycle of a layer
//   mac_cycle_o         : burst index (ROM / activation address)
//   layer_idx_o         : layer in progress
//   active_o, done_o    : busy / result captured
//   class_o             : captured class
//   rows_written_o      : saturating row count
//   mac/act_ovf_lat_o   : sticky overflow flags
//   timeout_o           : watchdog fired
//
// state          | meaning
// ---------------+-----------------------------------------------------
// ST_IDLE        | waiting for the row threshold
// ST_MAC_RUN     | issuing burst cycles of layer_idx_o (1 cycle if len 0)
// ST_MAC_DRAIN   | burst finished, waiting for layer writeback
// ST_RESULT_WAIT | all layers done, waiting for the softmax result
// ST_DONE        | result held until frame clear or abort
module npu_job_sequencer
    import npu_seq_pkg::*;
#(
    parameter int NUM_LAYERS  = 6,
    parameter int NUM_MACS    = 32,
    parameter int ROW_CNT_W   = 6,
    parameter int MAX_ROWS    = 63,
    parameter int CYCLES_W    = 12,
    parameter int CLASS_W     = 5,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic [ROW_CNT_W-1:0]                      cfg_start_thr_i,
    input  logic                                      write_row_p_i,
    input  logic                                      frame_clear_p_i,
    input  logic                                      abort_p_i,
    input  logic [NUM_LAYERS*CYCLES_W-1:0]            layer_len_i,
    input  logic [NUM_LAYERS*NUM_MACS-1:0]            layer_mac_mask_i,
    input  logic                                      layer_done_p_i,
    input  logic                                      result_valid_p_i,
    input  logic [CLASS_W-1:0]                        result_class_i,
    input  logic [NUM_MACS-1:0]                       mac_overflow_i,
    input  logic [NUM_MACS-1:0]                       act_overflow_i,
    output logic [NUM_MACS-1:0]                       mac_enable_o,
    output logic                                      mac_start_p_o,
    output logic                                      mac_last_p_o,
    output logic [CYCLES_W-1:0]                       mac_cycle_o,
    output logic [npu_seq_pkg::layer_w(NUM_LAYERS)-1:0] layer_idx_o,
    output logic                                      active_o,
    output logic                                      done_o,
    output logic [CLASS_W-1:0]                        class_o,
    output logic [ROW_CNT_W-1:0]                      rows_written_o,
    output logic                                      mac_ovf_lat_o,
    output logic                                      act_ovf_lat_o,
    output logic                                      timeout_o
);

    localparam int LAYER_W = layer_w(NUM_LAYERS);

    if ((NUM_LAYERS < 1) || (MAX_ROWS < 1) || (MAX_ROWS > (2**ROW_CNT_W) - 1) ||
        (CLASS_W > CLASS_W_MAX) || (WDOG_CYCLES < 1)) begin : g_bad_params
        $error("npu_job_sequencer: illegal parameter combination");
    end

    seq_state_t            state;
    logic                  thr_met;
    logic                  enter_layer;
    logic                  last_layer;
    logic [LAYER_W-1:0]    ent_idx;
    logic [CYCLES_W-1:0]   ent_len;
    logic [NUM_MACS-1:0]   ent_mask;
    logic [CYCLES_W-1:0]   cur_len;
    logic [CYCLES_W-1:0]   nxt_cycle;

`ifdef NPU_SEQ_WATCHDOG_EN
    localparam int               WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0]           wdog_cnt;
    logic                        timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    npu_seq_row_tracker #(
        .ROW_CNT_W (ROW_CNT_W),
        .MAX_ROWS  (MAX_ROWS)
    ) u_row_tracker (
        .clk          (clk),
        .resetn       (resetn),
        .write_row_p  (write_row_p_i),
        .clear_p      (frame_clear_p_i | abort_p_i),
        .start_thr    (cfg_start_thr_i),
        .rows_written (rows_written_o),
        .thr_met      (thr_met)
    );

    assign active_o   = (state == ST_MAC_RUN) || (state == ST_MAC_DRAIN) ||
                        (state == ST_RESULT_WAIT);
    assign last_layer = (layer_idx_o == LAYER_W'(NUM_LAYERS - 1));
    assign nxt_cycle  = mac_cycle_o + 1'b1;

    // Config of the layer in progress and of the layer about to be entered.
    always_comb begin
        ent_idx  = (state == ST_IDLE) ? '0 : layer_idx_o + 1'b1;
        cur_len  = '0;
        ent_len  = '0;
        ent_mask = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_idx_o == LAYER_W'(i)) begin
                cur_len = layer_len_i[i*CYCLES_W +: CYCLES_W];
            end
            if (ent_idx == LAYER_W'(i)) begin
                ent_len  = layer_len_i[i*CYCLES_W +: CYCLES_W];
                ent_mask = layer_mac_mask_i[i*NUM_MACS +: NUM_MACS];
            end
        end
    end

    // A frame clear in IDLE wipes the row count, so it also suppresses a start.
    always_comb begin
        enter_layer = 1'b0;
        case (state)
            ST_IDLE:      enter_layer = thr_met && !frame_clear_p_i;
            ST_MAC_RUN:   enter_layer = (cur_len == '0) && !last_layer;
            ST_MAC_DRAIN: enter_layer = layer_done_p_i && !last_layer;
            default:      enter_layer = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            mac_enable_o  <= '0;
            mac_start_p_o <= 1'b0;
            mac_last_p_o  <= 1'b0;
            mac_cycle_o   <= '0;
            layer_idx_o   <= '0;
            done_o        <= 1'b0;
            class_o       <= '0;
`ifdef NPU_SEQ_WATCHDOG_EN
            wdog_cnt      <= WDOG_LOAD;
            timeout_q     <= 1'b0;
`endif
        end else if (abort_p_i) begin
            state         <= ST_IDLE;
            mac_enable_o  <= '0;
            mac_start_p_o <= 1'b0;
            mac_last_p_o  <= 1'b0;
            mac_cycle_o   <= '0;
            layer_idx_o   <= '0;
            done_o        <= 1'b0;
            class_o       <= '0;
`ifdef NPU_SEQ_WATCHDOG_EN
            wdog_cnt      <= WDOG_LOAD;
            timeout_q     <= 1'b0;
`endif
        end else begin
            mac_start_p_o <= 1'b0;
            mac_last_p_o  <= 1'b0;
`ifdef NPU_SEQ_WATCHDOG_EN
            // Reloaded on every cycle except while dwelling in a wait state,
            // so each entry into DRAIN / RESULT_WAIT starts a fresh window.
            wdog_cnt      <= WDOG_LOAD;
`endif
            if (frame_clear_p_i) begin
                done_o    <= 1'b0;
                class_o   <= '0;
`ifdef NPU_SEQ_WATCHDOG_EN
                timeout_q <= 1'b0;
`endif
            end

            case (state)
                ST_IDLE: begin
                end

                ST_MAC_RUN: begin
                    if (cur_len == '0) begin
                        mac_enable_o <= '0;
                        if (last_layer) begin
                            state <= ST_RESULT_WAIT;
                        end
                    end else if (mac_cycle_o >= cur_len - 1'b1) begin
                        state        <= ST_MAC_DRAIN;
                        mac_enable_o <= '0;
                        mac_cycle_o  <= '0;
                    end else begin
                        mac_cycle_o  <= nxt_cycle;
                        mac_last_p_o <= (nxt_cycle == cur_len - 1'b1);
                    end
                end

                ST_MAC_DRAIN: begin
                    if (layer_done_p_i) begin
                        if (last_layer) begin
                            state <= ST_RESULT_WAIT;
                        end
                    end
`ifdef NPU_SEQ_WATCHDOG_EN
                    else if (wdog_cnt == '0) begin
                        state     <= ST_DONE;
                        done_o    <= 1'b1;
                        class_o   <= CLASS_ALL_ONES[CLASS_W-1:0];
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_cnt  <= wdog_cnt - 1'b1;
                    end
`endif
                end

                ST_RESULT_WAIT: begin
                    if (result_valid_p_i) begin
                        state   <= ST_DONE;
                        done_o  <= 1'b1;
                        class_o <= result_class_i;
                    end
`ifdef NPU_SEQ_WATCHDOG_EN
                    else if (wdog_cnt == '0) begin
                        state     <= ST_DONE;
                        done_o    <= 1'b1;
                        class_o   <= CLASS_ALL_ONES[CLASS_W-1:0];
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_cnt  <= wdog_cnt - 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    if (frame_clear_p_i) begin
                        state       <= ST_IDLE;
                        layer_idx_o <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A zero-length layer gets its one MAC_RUN cycle with no pulses
            // and no lanes enabled.
            if (enter_layer) begin
                state         <= ST_MAC_RUN;
                layer_idx_o   <= ent_idx;
                mac_cycle_o   <= '0;
                mac_start_p_o <= (ent_len != '0);
                mac_last_p_o  <= (ent_len == CYCLES_W'(1));
                mac_enable_o  <= (ent_len != '0) ? ent_mask : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mac_ovf_lat_o <= 1'b0;
            act_ovf_lat_o <= 1'b0;
        end else if (abort_p_i || frame_clear_p_i) begin
            mac_ovf_lat_o <= 1'b0;
            act_ovf_lat_o <= 1'b0;
        end else if (active_o) begin
            mac_ovf_lat_o <= mac_ovf_lat_o | (|mac_overflow_i);
            act_ovf_lat_o <= act_ovf_lat_o | (|act_overflow_i);
        end
    end

endmodule

// File: tb/tb_npu_job_sequencer.sv
`timescale 1ns/1ps
module tb_npu_job_sequencer;

    localparam int NL   = 3;
    localparam int NM   = 32;
    localparam int RW   = 6;
    localparam int MAXR = 63;
    localparam int CW   = 12;
    localparam int CLW  = 5;
    localparam int LW   = $clog2(NL) + 1;
`ifdef NPU_SEQ_WATCHDOG_EN
    localparam int WD   = 100;
`else
    localparam int WD   = 65535;
`endif

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [RW-1:0]      cfg_start_thr = '0;
    logic               write_row = 1'b0;
    logic               frame_clear = 1'b0;
    logic               abort = 1'b0;
    logic [NL*CW-1:0]   layer_len = '0;
    logic [NL*NM-1:0]   layer_mask = '0;
    logic               layer_done = 1'b0;
    logic               result_valid = 1'b0;
    logic [CLW-1:0]     result_class = '0;
    logic [NM-1:0]      mac_overflow = '0;
    logic [NM-1:0]      act_overflow = '0;
    logic [NM-1:0]      mac_enable_o;
    logic               mac_start_p_o, mac_last_p_o;
    logic [CW-1:0]      mac_cycle_o;
    logic [LW-1:0]      layer_idx_o;
    logic               active_o, done_o, mac_ovf_lat_o, act_ovf_lat_o, timeout_o;
    logic [CLW-1:0]     class_o;
    logic [RW-1:0]      rows_written_o;

    always #5 clk = ~clk;

    npu_job_sequencer #(
        .NUM_LAYERS(NL), .NUM_MACS(NM), .ROW_CNT_W(RW), .MAX_ROWS(MAXR),
        .CYCLES_W(CW), .CLASS_W(CLW), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_start_thr_i(cfg_start_thr),
        .write_row_p_i(write_row), .frame_clear_p_i(frame_clear), .abort_p_i(abort),
        .layer_len_i(layer_len), .layer_mac_mask_i(layer_mask),
        .layer_done_p_i(layer_done), .result_valid_p_i(result_valid),
        .result_class_i(result_class), .mac_overflow_i(mac_overflow),
        .act_overflow_i(act_overflow), .mac_enable_o(mac_enable_o),
        .mac_start_p_o(mac_start_p_o), .mac_last_p_o(mac_last_p_o),
        .mac_cycle_o(mac_cycle_o), .layer_idx_o(layer_idx_o), .active_o(active_o),
        .done_o(done_o), .class_o(class_o), .rows_written_o(rows_written_o),
        .mac_ovf_lat_o(mac_ovf_lat_o), .act_ovf_lat_o(act_ovf_lat_o),
        .timeout_o(timeout_o)
    );

    // Expected observable events: burst pulses (st/la set) or job completion.
    typedef struct {
        int            st;
        int            la;
        int            layer;
        int            cyc;
        logic [NM-1:0] en;
        int            cls;
        int            tmo;
    } ev_t;

    ev_t           exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            lens[NL];
    logic [NM-1:0] masks[NL];
    logic          done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int st, input int la, input int layer, input int cyc,
                           input logic [NM-1:0] en, input int cls, input int tmo);
        ev_t e;
        e.st = st; e.la = la; e.layer = layer; e.cyc = cyc;
        e.en = en; e.cls = cls; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // Reference: every non-empty layer shows start at cycle 0 and last at len-1.
    task automatic push_bursts(input int upto);
        for (int l = 0; l < upto; l++) begin
            if (lens[l] == 1) begin
                push_ev(1, 1, l, 0, masks[l], 0, 0);
            end else if (lens[l] > 1) begin
                push_ev(1, 0, l, 0, masks[l], 0, 0);
                push_ev(0, 1, l, lens[l] - 1, masks[l], 0, 0);
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (resetn) begin
            if (mac_start_p_o || mac_last_p_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_burst: got start=%0b last=%0b layer=%0d cycle=%0d, expected no pulse",
                             mac_start_p_o, mac_last_p_o, layer_idx_o, mac_cycle_o);
                end else begin
                    e = exp_q.pop_front();
                    check("burst_flags", {mac_start_p_o, mac_last_p_o}, {e.st[0], e.la[0]});
                    check("burst_layer", layer_idx_o, e.layer);
                    check("burst_cycle", mac_cycle_o, e.cyc);
                    check("burst_enable", mac_enable_o, e.en);
                end
            end
            if (done_o && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got done with class %0d, expected none", class_o);
                end else begin
                    e = exp_q.pop_front();
                    check("done_flags", {mac_start_p_o, mac_last_p_o}, {e.st[0], e.la[0]});
                    check("done_class", class_o, e.cls);
                    check("done_timeout", timeout_o, e.tmo);
                end
            end
        end
        done_prev <= done_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_row();
        write_row = 1'b1; tick(); write_row = 1'b0;
    endtask

    task automatic pulse_clear();
        frame_clear = 1'b1; tick(); frame_clear = 1'b0;
    endtask

    task automatic apply_cfg();
        for (int l = 0; l < NL; l++) begin
            layer_len[l*CW +: CW]  = CW'(lens[l]);
            layer_mask[l*NM +: NM] = masks[l];
        end
    endtask

    task automatic wait_last();
        int k = 0;
        while (!mac_last_p_o && k < 100) begin
            tick();
            k++;
        end
        n_tests++;
        if (!mac_last_p_o) begin
            n_fail++;
            $display("FAIL wait_last: got no mac_last_p_o in 100 cycles, expected one");
        end
    endtask

    // Leaves the bench one cycle after the DUT entered layer 0.
    task automatic start_job(input int thr, input int upto);
        pulse_clear();
        cfg_start_thr = RW'(thr);
        apply_cfg();
        push_bursts(upto);
        for (int r = 0; r < thr; r++) begin
            pulse_row();
            if (r < thr - 1) repeat ($urandom_range(0, 2)) tick();
        end
        check("idle_at_threshold_edge", active_o, 0);
        tick();
        check("start_latency", mac_start_p_o, lens[0] != 0);
        check("active_after_start", active_o, 1);
        check("rows_at_start", rows_written_o, thr);
    endtask

    // Entry: one cycle after entering layer 0. Exit: one cycle after entering RESULT_WAIT.
    task automatic run_layers();
        for (int l = 0; l < NL; l++) begin
            if (lens[l] == 0) begin
                tick();
            end else begin
                wait_last();
                tick();
                repeat ($urandom_range(0, 3)) tick();
                layer_done = 1'b1; tick(); layer_done = 1'b0;
            end
        end
    endtask

    task automatic finish_job(input int cls);
        repeat ($urandom_range(0, 3)) tick();
        push_ev(0, 0, 0, 0, '0, cls, 0);
        result_class = CLW'(cls);
        result_valid = 1'b1; tick(); result_valid = 1'b0;
        check("job_done", done_o, 1);
        check("job_class", class_o, cls);
        check("job_inactive", active_o, 0);
    endtask

    initial begin
        // reset
        repeat (3) tick();
        check("rst_enable", mac_enable_o, 0);
        check("rst_pulses", {mac_start_p_o, mac_last_p_o}, 0);
        check("rst_done_class", {done_o, class_o}, 0);
        check("rst_rows", rows_written_o, 0);
        check("rst_active_latches", {active_o, mac_ovf_lat_o, act_ovf_lat_o, timeout_o}, 0);
        resetn = 1'b1;
        tick();

        // auto-start disabled, saturation
        cfg_start_thr = '0;
        repeat (63) pulse_row();
        check("rows_63", rows_written_o, 63);
        check("thr0_no_start", active_o, 0);
        pulse_row();
        check("rows_saturate", rows_written_o, 63);
        check("thr0_still_idle", active_o, 0);

        // clears beat a simultaneous row write
        write_row = 1'b1; frame_clear = 1'b1; tick(); write_row = 1'b0; frame_clear = 1'b0;
        check("write_vs_clear", rows_written_o, 0);
        repeat (3) pulse_row();
        check("rows_3", rows_written_o, 3);
        write_row = 1'b1; abort = 1'b1; tick(); write_row = 1'b0; abort = 1'b0;
        check("write_vs_abort", rows_written_o, 0);

        // lens {4,1,0}, class 17, overflow lane 5 during layer 0
        lens[0] = 4; lens[1] = 1; lens[2] = 0;
        for (int l = 0; l < NL; l++) masks[l] = $urandom;
        start_job(2, NL);
        mac_overflow = '0; mac_overflow[5] = 1'b1; tick(); mac_overflow = '0;
        check("mac_ovf_set", mac_ovf_lat_o, 1);
        check("act_ovf_clear", act_ovf_lat_o, 0);
        run_layers();
        finish_job(17);
        check("mac_ovf_held_done", mac_ovf_lat_o, 1);
        repeat (5) tick();
        check("done_no_retrigger", active_o, 0);
        check("done_held", done_o, 1);
        pulse_clear();
        check("clear_ovf", mac_ovf_lat_o, 0);
        check("clear_done_class", {done_o, class_o}, 0);
        act_overflow = '1; tick(); act_overflow = '0;
        check("idle_ovf_ignored", act_ovf_lat_o, 0);

        // frame clear during a run only clears rows
        lens[0] = 5; lens[1] = 2; lens[2] = 1;
        for (int l = 0; l < NL; l++) masks[l] = $urandom;
        start_job(3, NL);
        pulse_clear();
        check("midrun_clear_rows", rows_written_o, 0);
        check("midrun_clear_active", active_o, 1);
        run_layers();
        finish_job($urandom_range(0, 31));

        // abort in MAC_DRAIN of layer 1
        lens[0] = 2; lens[1] = 3; lens[2] = 2;
        for (int l = 0; l < NL; l++) masks[l] = $urandom;
        start_job(2, 2);
        wait_last();
        tick();
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        wait_last();
        tick();
        check("drain_before_abort", {active_o, mac_enable_o == '0}, 2'b11);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_enable", mac_enable_o, 0);
        check("abort_cycle_layer", {mac_cycle_o, layer_idx_o}, 0);
        check("abort_status", {active_o, done_o, class_o, timeout_o}, 0);
        check("abort_rows_latches", {rows_written_o, mac_ovf_lat_o, act_ovf_lat_o}, 0);
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        repeat (3) tick();
        check("late_layer_done_ignored", {active_o, layer_idx_o}, 0);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            for (int l = 0; l < NL; l++) begin
                lens[l]  = $urandom_range(0, 5);
                masks[l] = $urandom;
            end
            start_job($urandom_range(1, 4), NL);
            run_layers();
            finish_job($urandom_range(0, 31));
        end

`ifdef NPU_SEQ_WATCHDOG_EN
        begin
            int k = 0;
            lens[0] = 1; lens[1] = 0; lens[2] = 0;
            masks[0] = $urandom; masks[1] = '0; masks[2] = '0;
            start_job(1, NL);
            run_layers();
            push_ev(0, 0, 0, 0, '0, 31, 1);
            while (!done_o && k < 300) begin
                tick();
                k++;
            end
            check("wdog_latency", k, 100);
            check("wdog_timeout", timeout_o, 1);
            check("wdog_class", class_o, 31);
            pulse_clear();
            check("wdog_clear", timeout_o, 0);
        end
`else
        check("no_wdog_timeout", timeout_o, 0);
`endif

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
